// File: rtl/tracker_pkg.sv
// Shared constants, FSM state encoding and overlay edge helper for the centroid tracker.
// Contents: active-area geometry, accumulator widths, reset centroid, state_t, on_edge().
// No ports; imported by mask_centroid_tracker.
package tracker_pkg;

   localparam int COORD_W  = 11;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int SUM_W    = 30;   // 639*640*480 fits in 30 bits
   localparam int CNT_W    = 19;   // 640*480 fits in 19 bits

   localparam logic [COORD_W-1:0] DEF_X = 11'd320;
   localparam logic [COORD_W-1:0] DEF_Y = 11'd240;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_DIV_X,
      ST_DIV_Y,
      ST_UPDATE
   } state_t;

   // True when c lies in one of the two 2-px bands (centre-half-2, centre-half]
   // or (centre+half, centre+half+2]. Done in signed arithmetic with two guard
   // bits so a box near 0 produces negative edges instead of wrapping.
   function automatic logic on_edge(input logic [COORD_W-1:0] c,
                                    input logic [COORD_W-1:0] centre,
                                    input logic [COORD_W-1:0] half);
      logic signed [COORD_W+1:0] cs;
      logic signed [COORD_W+1:0] lo;
      logic signed [COORD_W+1:0] hi;
      cs = $signed({2'b00, c});
      lo = $signed({2'b00, centre}) - $signed({2'b00, half});
      hi = $signed({2'b00, centre}) + $signed({2'b00, half});
      return ((cs > lo - 13'sd2) && (cs <= lo)) || ((cs > hi) && (cs <= hi + 13'sd2));
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; DIVIDEND_W cycles from start to done.
// Ports: start (ignored while busy), dividend/divisor (sampled on start), quotient (valid with done),
//        busy (high while iterating), done (1-cycle pulse). Synchronous active-high rst aborts.
module seq_divider #(
   parameter int DIVIDEND_W = 30,
   parameter int DIVISOR_W  = 19
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2(DIVIDEND_W + 1);

   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   logic [DIVIDEND_W-1:0] dvd_q;
   logic [DIVISOR_W:0]    rem_q;
   logic [DIVISOR_W-1:0]  dsr_q;
   logic [CW-1:0]         cnt_q;
   logic                  busy_q;
   logic                  done_q;

   logic [DIVISOR_W:0]    rem_sh;
   logic [DIVISOR_W:0]    rem_d;
   logic                  ge;

   always_comb begin
      rem_sh = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
      // A set top remainder bit means the true shifted value exceeds the divisor.
      ge     = rem_q[DIVISOR_W] | (rem_sh >= {1'b0, dsr_q});
      rem_d  = ge ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start && !busy_q) begin
            dvd_q  <= dividend;
            rem_q  <= '0;
            dsr_q  <= divisor;
            cnt_q  <= CW'(DIVIDEND_W);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            rem_q <= rem_d;
            dvd_q <= {dvd_q[DIVIDEND_W-2:0], ge};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign quotient = dvd_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: rtl/mask_centroid_tracker.sv
// Accumulates matching-pixel coordinates per frame, divides at frame end to get the centroid,
// and draws a registered 2-px box outline around it.
// Ports: vga_x/vga_y scan position, p_in mask (MASK_LAT cycles late); box_x/box_y centroid,
//        cen_valid / frame_drop pulses, target_lost level, overlay bit (1-cycle latency).
module mask_centroid_tracker
   import tracker_pkg::*;
#(
   parameter int MASK_LAT  = 2,
   parameter int MIN_COUNT = 64,
   parameter int HALF_BOX  = 50
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] vga_x,
   input  logic [COORD_W-1:0] vga_y,
   input  logic [7:0]         p_in,
   output logic [COORD_W-1:0] box_x,
   output logic [COORD_W-1:0] box_y,
   output logic               cen_valid,
   output logic               target_lost,
   output logic               frame_drop,
   output logic               overlay
);

   localparam logic [COORD_W-1:0] HALF_C = COORD_W'(HALF_BOX);

   // Coordinate delay line so dx/dy line up with the late mask.
   logic [COORD_W-1:0] dx_q [MASK_LAT];
   logic [COORD_W-1:0] dy_q [MASK_LAT];
   logic [COORD_W-1:0] dx, dy;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MASK_LAT; i++) begin
            dx_q[i] <= '0;
            dy_q[i] <= '0;
         end
      end else begin
         dx_q[0] <= vga_x;
         dy_q[0] <= vga_y;
         for (int i = 1; i < MASK_LAT; i++) begin
            dx_q[i] <= dx_q[i-1];
            dy_q[i] <= dy_q[i-1];
         end
      end
   end

   assign dx = dx_q[MASK_LAT-1];
   assign dy = dy_q[MASK_LAT-1];

   // Accumulators; *_d includes the current pixel so the frame-end snapshot is complete.
   logic               hit, frame_end;
   logic [SUM_W-1:0]   xsum_q, ysum_q, xsum_d, ysum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   assign hit       = (dx < COORD_W'(H_ACTIVE)) && (dy < COORD_W'(V_ACTIVE)) && (p_in != 8'd0);
   assign frame_end = (dx == COORD_W'(H_ACTIVE - 1)) && (dy == COORD_W'(V_ACTIVE - 1));
   assign xsum_d    = xsum_q + (hit ? SUM_W'(dx) : '0);
   assign ysum_d    = ysum_q + (hit ? SUM_W'(dy) : '0);
   assign cnt_d     = cnt_q + CNT_W'(hit);

   always_ff @(posedge clk) begin
      if (rst || frame_end) begin
         xsum_q <= '0;
         ysum_q <= '0;
         cnt_q  <= '0;
      end else begin
         xsum_q <= xsum_d;
         ysum_q <= ysum_d;
         cnt_q  <= cnt_d;
      end
   end

   // Single divider shared between x and y.
   state_t             state_q;
   logic [SUM_W-1:0]   snap_x_q, snap_y_q;
   logic [CNT_W-1:0]   snap_cnt_q;
   logic               start_q, div_start, div_busy, div_done;
   logic [SUM_W-1:0]   div_dvd, div_quot;
   logic [COORD_W-1:0] quot_c;

   assign div_start = start_q & ~div_busy;
   assign div_dvd   = (state_q == ST_DIV_Y) ? snap_y_q : snap_x_q;
   // The mean of in-frame coordinates always fits; the clamp only keeps upper bits meaningful.
   assign quot_c    = (|div_quot[SUM_W-1:COORD_W]) ? '1 : div_quot[COORD_W-1:0];

   seq_divider #(
      .DIVIDEND_W(SUM_W),
      .DIVISOR_W (CNT_W)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .start   (div_start),
      .dividend(div_dvd),
      .divisor (snap_cnt_q),
      .quotient(div_quot),
      .busy    (div_busy),
      .done    (div_done)
   );

   logic [COORD_W-1:0] qx_q, qy_q, box_x_q, box_y_q;
   logic               cen_valid_q, target_lost_q, frame_drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         snap_x_q      <= '0;
         snap_y_q      <= '0;
         snap_cnt_q    <= '0;
         start_q       <= 1'b0;
         qx_q          <= '0;
         qy_q          <= '0;
         box_x_q       <= DEF_X;
         box_y_q       <= DEF_Y;
         cen_valid_q   <= 1'b0;
         target_lost_q <= 1'b0;
         frame_drop_q  <= 1'b0;
      end else begin
         cen_valid_q  <= 1'b0;
         start_q      <= 1'b0;
         // A frame ending while a previous one is still in flight is discarded.
         frame_drop_q <= frame_end && (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (frame_end) begin
                  snap_x_q   <= xsum_d;
                  snap_y_q   <= ysum_d;
                  snap_cnt_q <= cnt_d;
                  state_q    <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (snap_cnt_q < CNT_W'(MIN_COUNT)) begin
                  target_lost_q <= 1'b1;
                  state_q       <= ST_IDLE;
               end else begin
                  target_lost_q <= 1'b0;
                  start_q       <= 1'b1;
                  state_q       <= ST_DIV_X;
               end
            end
            ST_DIV_X: begin
               if (div_done) begin
                  qx_q    <= quot_c;
                  start_q <= 1'b1;
                  state_q <= ST_DIV_Y;
               end
            end
            ST_DIV_Y: begin
               if (div_done) begin
                  qy_q    <= quot_c;
                  state_q <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               box_x_q     <= qx_q;
               box_y_q     <= qy_q;
               cen_valid_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Outline uses the live scan position and the currently held centre.
   logic overlay_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overlay_q <= 1'b0;
      end else begin
         overlay_q <= on_edge(vga_x, box_x_q, HALF_C) | on_edge(vga_y, box_y_q, HALF_C);
      end
   end

   assign box_x       = box_x_q;
   assign box_y       = box_y_q;
   assign cen_valid   = cen_valid_q;
   assign target_lost = target_lost_q;
   assign frame_drop  = frame_drop_q;
   assign overlay     = overlay_q;

endmodule

// File: tb/tb_mask_centroid_tracker.sv
// Bench for mask_centroid_tracker: table of frames plus hand-written corner sequences.
// Expected centroids are queued when a frame is driven and popped on cen_valid.
// A second instance with MIN_COUNT=1 covers the single frame-end-pixel case.
module tb_mask_centroid_tracker;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] vga_x, vga_y;
   logic [7:0]  p_in;

   logic [10:0] box_x, box_y, box_x1, box_y1;
   logic        cen_valid, target_lost, frame_drop, overlay;
   logic        cen_valid1, target_lost1, frame_drop1, overlay1;

   always #5 clk = ~clk;

   mask_centroid_tracker u_dut (
      .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .p_in(p_in),
      .box_x(box_x), .box_y(box_y), .cen_valid(cen_valid), .target_lost(target_lost),
      .frame_drop(frame_drop), .overlay(overlay)
   );

   mask_centroid_tracker #(.MIN_COUNT(1)) u_dut1 (
      .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .p_in(p_in),
      .box_x(box_x1), .box_y(box_y1), .cen_valid(cen_valid1), .target_lost(target_lost1),
      .frame_drop(frame_drop1), .overlay(overlay1)
   );

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int cv_cnt = 0;
   int cv_cyc = 0;
   int drop_cnt = 0;
   int fe_cyc = 0;

   typedef struct { int bx; int by; } exp_t;
   exp_t sb_q[$];
   exp_t e_mon;

   typedef struct { int x0; int y0; int w; int h; int vld; int bx; int by; int lost; } vec_t;
   vec_t tbl[6];

   logic [7:0] p_hist [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Scoreboard side: every cen_valid pulse must match the oldest queued centroid.
   always @(negedge clk) begin
      if (cen_valid) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_cen_valid: got pulse with box=(%0d,%0d), want no pulse",
                     box_x, box_y);
         end else begin
            e_mon = sb_q.pop_front();
            chk("sb_box_x", int'(box_x), e_mon.bx);
            chk("sb_box_y", int'(box_y), e_mon.by);
         end
         cv_cnt++;
         cv_cyc = cyc;
      end
      if (frame_drop) drop_cnt++;
   end

   // One pixel clock: new coordinates now, mask for the coordinates of two steps ago.
   task automatic step(input int x, input int y, input int p);
      vga_x     = 11'(x);
      vga_y     = 11'(y);
      p_in      = p_hist[1];
      p_hist[1] = p_hist[0];
      p_hist[0] = 8'(p);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(700, 700, 0);
   endtask

   // Rectangle of matches (mask value 1 or 255), two out-of-area distractors, then frame end.
   task automatic do_frame(input int x0, input int y0, input int w, input int h);
      step(640, y0, 255);
      step(x0, 480, 255);
      for (int yy = y0; yy < y0 + h; yy++)
         for (int xx = x0; xx < x0 + w; xx++)
            step(xx, yy, (((xx + yy) % 3) == 0) ? 1 : 255);
      if (!((x0 + w - 1 == 639) && (y0 + h - 1 == 479)))
         step(639, 479, 0);
      step(700, 700, 0);
      fe_cyc = cyc;
      step(700, 700, 0);
   endtask

   task automatic wait_cv(input int cv0, input string name);
      for (int k = 0; k < 100; k++) begin
         if (cv_cnt != cv0) break;
         step(700, 700, 0);
      end
      chk(name, (cv_cnt != cv0) ? 1 : 0, 1);
      chk({name, "_lat_le70"}, ((cv_cyc - fe_cyc) <= 70) ? 1 : 0, 1);
   endtask

   task automatic ov(input int x, input int y, input int exp, input string name);
      step(x, y, 0);
      chk(name, int'(overlay), exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, want finish");
      $fatal(1);
   end

   initial begin
      int cv0, d0;

      tbl[0] = '{100, 200, 10, 10, 1, 104, 204, 0};
      tbl[1] = '{  0,   0,  8,  8, 1,   3,   3, 0};   // exactly MIN_COUNT
      tbl[2] = '{630, 470, 10, 10, 1, 634, 474, 0};   // last pixel is the frame end
      tbl[3] = '{ 20,  30,  5,  8, 0, 634, 474, 1};   // 40 pixels
      tbl[4] = '{ 20,  30,  7,  9, 0, 634, 474, 1};   // MIN_COUNT-1
      tbl[5] = '{300,  50, 10, 10, 1, 304,  54, 0};

      rst = 1'b1;
      vga_x = 11'd700;
      vga_y = 11'd700;
      p_in = 8'd0;
      p_hist[0] = 8'd0;
      p_hist[1] = 8'd0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_box_x", int'(box_x), 320);
      chk("rst_box_y", int'(box_y), 240);
      chk("rst_cen_valid", int'(cen_valid), 0);
      chk("rst_target_lost", int'(target_lost), 0);
      chk("rst_frame_drop", int'(frame_drop), 0);
      chk("rst_overlay", int'(overlay), 0);
      rst = 1'b0;
      idle(3);

      ov(270, 240, 1, "ov_left_inner");
      ov(271, 240, 0, "ov_left_inside");
      ov(371, 240, 1, "ov_right_inner");
      ov(373, 240, 0, "ov_right_outside");
      ov(320, 189, 1, "ov_top_outer");
      ov(320, 188, 0, "ov_top_beyond");

      for (int i = 0; i < 6; i++) begin
         cv0 = cv_cnt;
         if (tbl[i].vld != 0) sb_q.push_back('{tbl[i].bx, tbl[i].by});
         do_frame(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h);
         if (tbl[i].vld != 0) begin
            wait_cv(cv0, $sformatf("v%0d_cen_valid", i));
         end else begin
            idle(80);
            chk($sformatf("v%0d_no_cen_valid", i), cv_cnt - cv0, 0);
         end
         chk($sformatf("v%0d_target_lost", i), int'(target_lost), tbl[i].lost);
         chk($sformatf("v%0d_box_x", i), int'(box_x), tbl[i].bx);
         chk($sformatf("v%0d_box_y", i), int'(box_y), tbl[i].by);
         if (i == 1) begin
            // Box at (3,3): left/top edges are negative and must not wrap.
            ov(54, 240, 1, "ov_near0_right");
            ov(2001, 240, 0, "ov_near0_wrap_x");
            ov(2000, 240, 0, "ov_near0_wrap_x2");
            ov(3, 54, 1, "ov_near0_bottom");
         end
      end

      // Second frame end 10 cycles after the first while dividing.
      cv0 = cv_cnt;
      d0 = drop_cnt;
      sb_q.push_back('{204, 304});
      do_frame(200, 300, 10, 10);
      idle(7);
      step(639, 479, 0);
      idle(2);
      wait_cv(cv0, "drop_cen_valid");
      chk("drop_pulses", drop_cnt - d0, 1);
      chk("drop_target_lost", int'(target_lost), 0);
      chk("drop_box_x", int'(box_x), 204);
      chk("drop_box_y", int'(box_y), 304);

      // Only the frame-end pixel matches.
      cv0 = cv_cnt;
      do_frame(639, 479, 1, 1);
      idle(80);
      chk("fe_pix_no_cv", cv_cnt - cv0, 0);
      chk("fe_pix_lost", int'(target_lost), 1);
      chk("fe_pix_box_x_hold", int'(box_x), 204);
      chk("fe_pix_box1_x", int'(box_x1), 639);
      chk("fe_pix_box1_y", int'(box_y1), 479);
      cv0 = cv_cnt;
      sb_q.push_back('{104, 204});
      do_frame(100, 200, 10, 10);
      wait_cv(cv0, "after_fe_cen_valid");
      idle(2);
      chk("after_fe_lost", int'(target_lost), 0);
      chk("after_fe_box1_x", int'(box_x1), 104);
      chk("after_fe_box1_y", int'(box_y1), 204);

      // Reset in the middle of the y division.
      do_frame(300, 100, 10, 10);
      idle(45);
      rst = 1'b1;
      step(700, 700, 0);
      rst = 1'b0;
      chk("midrst_box_x", int'(box_x), 320);
      chk("midrst_box_y", int'(box_y), 240);
      chk("midrst_cen_valid", int'(cen_valid), 0);
      cv0 = cv_cnt;
      idle(80);
      chk("midrst_no_cv", cv_cnt - cv0, 0);
      sb_q.push_back('{54, 64});
      do_frame(50, 60, 10, 10);
      wait_cv(cv0, "midrst_next_cv");
      chk("midrst_next_box_x", int'(box_x), 54);
      chk("midrst_next_box_y", int'(box_y), 64);
      chk("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
